// File: rtl/fmac_issue_ctrl_pkg.sv
// Shared FMAC definitions: operand/flag widths, rounding-mode type and the
// per-stage tracking record that follows each op down the datapath.
package fpu_defs_fmac;
  localparam int C_FMAC_OP_W      = 32;
  localparam int C_FMAC_FLAG_W    = 5;
  localparam int C_FMAC_EXP       = 8;
  localparam int C_FMAC_MANT      = 23;
  localparam int C_FMAC_ID_W      = 2;
  localparam int C_FMAC_TAG_MAX_W = 16;

  typedef logic [2:0] fmac_rnd_t;

  // id/tag sized for the largest supported configuration; unused upper bits stay 0
  typedef struct packed {
    logic                        vld;
    logic [C_FMAC_ID_W-1:0]      id;
    logic [C_FMAC_TAG_MAX_W-1:0] tag;
  } fmac_trk_t;
endpackage

// File: rtl/fmac_issue_ctrl_rr_arb.sv
// Round-robin arbiter: winner is the first request at or after the pointer.
// Latency: combinational grant, pointer updates on the grant edge.
// Backpressure: en low suppresses all grants and freezes the pointer.
module fmac_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win
);
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        idx = IW'((int'(ptr_q) + i) % N);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          win      = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (found)
      ptr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/fmac_issue_ctrl.sv
// Issue/retire control for one shared pipelined FMAC datapath across requesters.
// Latency: grant in cycle t returns Res_valid_SO in t+C_LAT+1 when unstalled.
// Backpressure: a full, unpopped result buffer with a valid last stage stalls every stage.
module fmac_issue_ctrl
  import fpu_defs_fmac::*;
#(
  parameter int C_NUM_REQ = 2,
  parameter int C_LAT     = 3,
  parameter int C_TAG_W   = 4
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RBI,
  input  logic                               Flush_SI,
  input  logic [C_NUM_REQ-1:0]               Req_SI,
  output logic [C_NUM_REQ-1:0]               Gnt_SO,
  input  logic [C_NUM_REQ*C_FMAC_OP_W-1:0]   Op_a_DI,
  input  logic [C_NUM_REQ*C_FMAC_OP_W-1:0]   Op_b_DI,
  input  logic [C_NUM_REQ*C_FMAC_OP_W-1:0]   Op_c_DI,
  input  logic [C_NUM_REQ*3-1:0]             Rnd_mode_DI,
  input  logic [C_NUM_REQ*C_TAG_W-1:0]       Tag_DI,
  output logic                               Dp_en_SO,
  output logic                               Dp_vld_SO,
  output logic [C_FMAC_OP_W-1:0]             Dp_op_a_DO,
  output logic [C_FMAC_OP_W-1:0]             Dp_op_b_DO,
  output logic [C_FMAC_OP_W-1:0]             Dp_op_c_DO,
  output fmac_rnd_t                          Dp_rnd_DO,
  input  logic [C_FMAC_OP_W-1:0]             Dp_res_DI,
  input  logic [C_FMAC_FLAG_W-1:0]           Dp_flags_DI,
  output logic [C_NUM_REQ-1:0]               Res_valid_SO,
  input  logic [C_NUM_REQ-1:0]               Res_ready_SI,
  output logic [C_FMAC_OP_W-1:0]             Res_DO,
  output logic [C_FMAC_FLAG_W-1:0]           Res_flags_DO,
  output logic [C_TAG_W-1:0]                 Res_tag_DO,
  output logic                               Busy_SO
);
  localparam int IW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

  fmac_trk_t                trk_q [C_LAT];
  fmac_trk_t                trk_in;
  logic                     full_q;
  logic [IW-1:0]            buf_id_q;
  logic [C_FMAC_OP_W-1:0]   res_q;
  logic [C_FMAC_FLAG_W-1:0] flags_q;
  logic [C_TAG_W-1:0]       tag_q;
  logic [IW-1:0]            win;
  logic                     last_vld;
  logic                     pop;
  logic                     arb_en;

  assign last_vld = trk_q[C_LAT-1].vld;
  assign pop      = full_q & Res_ready_SI[buf_id_q];
  assign Dp_en_SO = ~last_vld | ~full_q | pop;
  // reset gating keeps grants at zero while requests are held through reset
  assign arb_en   = Rst_RBI & Dp_en_SO & ~Flush_SI;

  fmac_rr_arb #(.N(C_NUM_REQ), .IW(IW)) u_arb (
    .clk   (Clk_CI),
    .rst_n (Rst_RBI),
    .req   (Req_SI),
    .en    (arb_en),
    .gnt   (Gnt_SO),
    .win   (win)
  );

  assign Dp_vld_SO = |Gnt_SO;

  always_comb begin
    Dp_op_a_DO = '0;
    Dp_op_b_DO = '0;
    Dp_op_c_DO = '0;
    Dp_rnd_DO  = '0;
    trk_in     = '0;
    if (Dp_vld_SO) begin
      Dp_op_a_DO = Op_a_DI[int'(win)*C_FMAC_OP_W +: C_FMAC_OP_W];
      Dp_op_b_DO = Op_b_DI[int'(win)*C_FMAC_OP_W +: C_FMAC_OP_W];
      Dp_op_c_DO = Op_c_DI[int'(win)*C_FMAC_OP_W +: C_FMAC_OP_W];
      Dp_rnd_DO  = Rnd_mode_DI[int'(win)*3 +: 3];
      trk_in.vld = 1'b1;
      trk_in.id  = C_FMAC_ID_W'(win);
      trk_in.tag = C_FMAC_TAG_MAX_W'(Tag_DI[int'(win)*C_TAG_W +: C_TAG_W]);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < C_LAT; i++) trk_q[i] <= '0;
      full_q   <= 1'b0;
      buf_id_q <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
    end else if (Flush_SI) begin
      for (int i = 0; i < C_LAT; i++) trk_q[i].vld <= 1'b0;
      full_q <= 1'b0;
    end else begin
      if (Dp_en_SO) begin
        trk_q[0] <= trk_in;
        for (int i = 1; i < C_LAT; i++) trk_q[i] <= trk_q[i-1];
      end
      // load wins over pop: a same-cycle pop+load keeps the buffer full with the new result
      if (Dp_en_SO && last_vld) begin
        full_q   <= 1'b1;
        buf_id_q <= IW'(trk_q[C_LAT-1].id);
        res_q    <= Dp_res_DI;
        flags_q  <= Dp_flags_DI;
        tag_q    <= trk_q[C_LAT-1].tag[C_TAG_W-1:0];
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    Res_valid_SO = '0;
    if (full_q) Res_valid_SO[buf_id_q] = 1'b1;
    Busy_SO = full_q;
    for (int i = 0; i < C_LAT; i++) Busy_SO = Busy_SO | trk_q[i].vld;
  end

  assign Res_DO       = res_q;
  assign Res_flags_DO = flags_q;
  assign Res_tag_DO   = tag_q;
endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Directed bench for fmac_issue_ctrl with a behavioural 3-stage FMAC stub and a result scoreboard.
module tb_fmac_issue_ctrl;
  localparam int LAT = 3;

  typedef struct {
    logic [1:0]  vld;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [1:0]  req, gnt, rdy, res_vld;
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [31:0] op_c [2];
  logic [2:0]  rnd  [2];
  logic [3:0]  tag  [2];
  logic        dp_en, dp_vld, busy;
  logic [31:0] dp_a, dp_b, dp_c, dp_res, res;
  logic [2:0]  dp_rnd;
  logic [4:0]  dp_flags, res_flags;
  logic [3:0]  res_tag;

  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  logic [31:0] pc [LAT];
  logic [2:0]  pr [LAT];

  exp_t sb [$];
  int   total = 0, bad = 0, n_pops = 0, k = 0;

  always #5 clk = ~clk;

  fmac_issue_ctrl #(.C_NUM_REQ(2), .C_LAT(LAT), .C_TAG_W(4)) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Flush_SI     (flush),
    .Req_SI       (req),
    .Gnt_SO       (gnt),
    .Op_a_DI      ({op_a[1], op_a[0]}),
    .Op_b_DI      ({op_b[1], op_b[0]}),
    .Op_c_DI      ({op_c[1], op_c[0]}),
    .Rnd_mode_DI  ({rnd[1], rnd[0]}),
    .Tag_DI       ({tag[1], tag[0]}),
    .Dp_en_SO     (dp_en),
    .Dp_vld_SO    (dp_vld),
    .Dp_op_a_DO   (dp_a),
    .Dp_op_b_DO   (dp_b),
    .Dp_op_c_DO   (dp_c),
    .Dp_rnd_DO    (dp_rnd),
    .Dp_res_DI    (dp_res),
    .Dp_flags_DI  (dp_flags),
    .Res_valid_SO (res_vld),
    .Res_ready_SI (rdy),
    .Res_DO       (res),
    .Res_flags_DO (res_flags),
    .Res_tag_DO   (res_tag),
    .Busy_SO      (busy)
  );

  function automatic real f2d(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // datapath stub: all stages advance on Dp_en_SO, a + b*c evaluated at the last stage
  always @(posedge clk) begin
    if (dp_en) begin
      pa[0] <= dp_a; pb[0] <= dp_b; pc[0] <= dp_c; pr[0] <= dp_rnd;
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; pc[i] <= pc[i-1]; pr[i] <= pr[i-1];
      end
    end
  end
  assign dp_res   = d2f(f2d(pa[LAT-1]) + f2d(pb[LAT-1]) * f2d(pc[LAT-1]));
  assign dp_flags = {2'b00, pr[LAT-1]};

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic next_op(input int r);
    k++;
    op_a[r] = d2f(real'(k));
    op_b[r] = 32'h40000000;
    op_c[r] = d2f(real'(k % 5 + 1));
    tag[r]  = 4'(k);
    rnd[r]  = 3'(k);
  endtask

  // scoreboard: push on each transfer, pop and compare on each result handshake
  always begin : monitor
    exp_t e;
    int   w;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (|(res_vld & rdy)) begin
        n_pops++;
        if (sb.size() == 0) chk("sb_underflow", 32'(res_vld), 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_id",   32'(res_vld),   32'(e.vld));
          chk("sb_tag",  32'(res_tag),   32'(e.tag));
          chk("sb_res",  res,            e.res);
          chk("sb_flag", 32'(res_flags), 32'(e.flg));
        end
      end
      if (flush) sb.delete();
      else if (|(req & gnt)) begin
        w     = gnt[1] ? 1 : 0;
        e.vld = gnt;
        e.tag = tag[w];
        e.res = d2f(f2d(op_a[w]) + f2d(op_b[w]) * f2d(op_c[w]));
        e.flg = {2'b00, rnd[w]};
        sb.push_back(e);
      end
    end
  end

  task automatic drain(input string nm);
    req = 2'b00;
    rdy = 2'b11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #3;
      if (!busy && sb.size() == 0) break;
    end
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic stream(input logic [1:0] rmask, input int nops, input logic [1:0] rdy_lo,
                        input int rdy_cyc, input int chk_cyc, input logic [1:0] exp_rv,
                        input string nm);
    int got   = 0;
    int lastw = -1;
    int p0    = n_pops;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (lastw >= 0) next_op(lastw);
      lastw = -1;
      rdy = (c >= rdy_cyc) ? 2'b11 : rdy_lo;
      req = (got < nops) ? rmask : 2'b00;
      #1;
      if (c == chk_cyc) begin
        chk({nm, "_stall_en"}, 32'(dp_en), 32'd0);
        chk({nm, "_stall_gnt"}, 32'(gnt), 32'd0);
        chk({nm, "_stall_rv"}, 32'(res_vld), 32'(exp_rv));
        chk({nm, "_stall_busy"}, 32'(busy), 32'd1);
        chk({nm, "_stall_pops"}, 32'(n_pops - p0), 32'd0);
      end
      if (|(req & gnt)) begin
        got++;
        lastw = gnt[1] ? 1 : 0;
      end
    end
    req = 2'b00;
    chk({nm, "_issued"}, 32'(got), 32'(nops));
  endtask

  initial begin : main
    int c0, c1, lastw, p0;
    rst_n = 1'b0; flush = 1'b0; req = 2'b11; rdy = 2'b00;
    next_op(0);
    next_op(1);

    // reset held three cycles with both requests raised
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt",  32'(gnt),     32'd0);
    chk("rst_rv",   32'(res_vld), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_en",   32'(dp_en),   32'd1);
    chk("rst_dvld", 32'(dp_vld),  32'd0);

    // single op: 1 + 2*3 = 7.0
    @(negedge clk);
    rst_n = 1'b1; req = 2'b00; rdy = 2'b11;
    op_a[0] = 32'h3F800000; op_b[0] = 32'h40000000; op_c[0] = 32'h40400000;
    tag[0] = 4'd5; rnd[0] = 3'd1;
    @(negedge clk);
    req = 2'b01;
    #1;
    chk("single_gnt", 32'(gnt), 32'd1);
    chk("single_dpa", dp_a, 32'h3F800000);
    @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("single_early", 32'(res_vld), 32'd0);
    @(negedge clk);
    #1;
    chk("single_rv",   32'(res_vld),   32'd1);
    chk("single_tag",  32'(res_tag),   32'd5);
    chk("single_res",  res,            32'h40E00000);
    chk("single_flag", 32'(res_flags), 32'd1);
    drain("single");

    // fairness: pointer restarts at 0 after reset, both requesting for 8 cycles
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_op(0);
    next_op(1);
    c0 = 0; c1 = 0; lastw = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lastw >= 0) next_op(lastw);
      req = 2'b11;
      #1;
      chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (gnt[0]) c0++;
      if (gnt[1]) c1++;
      lastw = gnt[1] ? 1 : 0;
    end
    chk("rr_en", 32'(dp_en), 32'd1);
    chk("rr_cnt0", 32'(c0), 32'd4);
    chk("rr_cnt1", 32'(c1), 32'd4);
    drain("rr");

    // backpressure: requester 0 not ready for 10 cycles during a 6-op stream
    p0 = n_pops;
    stream(2'b01, 6, 2'b10, 10, 9, 2'b01, "bp");
    drain("bp");
    chk("bp_pops", 32'(n_pops - p0), 32'd6);

    // cross-ID: buffered result for requester 1 must ignore ready[0]
    p0 = n_pops;
    stream(2'b10, 2, 2'b01, 30, 8, 2'b10, "xid");
    drain("xid");
    chk("xid_pops", 32'(n_pops - p0), 32'd2);

    // flush with three ops in flight and a full buffer; pop in the flush cycle
    stream(2'b01, 4, 2'b00, 99, 6, 2'b01, "fl");
    @(negedge clk);
    flush = 1'b1; req = 2'b01; rdy = 2'b01;
    #1;
    chk("fl_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    flush = 1'b0; req = 2'b00; rdy = 2'b00;
    #1;
    chk("fl_busy", 32'(busy),    32'd0);
    chk("fl_rv",   32'(res_vld), 32'd0);
    chk("fl_en",   32'(dp_en),   32'd1);

    // same scenario with a one-cycle reset instead of flush
    stream(2'b01, 4, 2'b00, 99, 6, 2'b01, "mr");
    @(negedge clk);
    rst_n = 1'b0; req = 2'b01;
    #1;
    chk("mr_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 2'b00;
    #1;
    chk("mr_busy", 32'(busy),    32'd0);
    chk("mr_rv",   32'(res_vld), 32'd0);

    // no stale result may leak out after flush/reset
    p0 = n_pops;
    stream(2'b01, 1, 2'b00, 0, -1, 2'b00, "post");
    drain("post");
    chk("post_pops", 32'(n_pops - p0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
